counter_cmd_sequencer: RTL and testbench
========================================

Name: counter_cmd_sequencer

Overview:
Initiator-side companion to the N-bit up/down counter with load and threshold flag. It drives the counter's enable/load/dec/load_ref_value controls through all 8 control combinations in a fixed order, holding each for a parameterised number of cycles. It monitors the counter's counterN/threshold feedback and reports summary results. It is used on-board for self-test, replacing the hand-written stimulus sequence.

Parameters:
N, 4, counter width; width of ref_value, load_ref_value, counterN, max_count
HOLD_CYCLES, 20, cycles each control combination is held; legal range 1..65535

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
ref_value  input  N  value to present on load_ref_value, captured at start
counterN  input  N  count fed back from the counter
threshold  input  1  threshold flag fed back from the counter
enable  output  1  counter enable
load  output  1  counter load
dec  output  1  counter direction (1 = down)
load_ref_value  output  N  counter load value
step  output  3  current combination index, {enable,load,dec}
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at end of sweep
thr_hits  output  8  RUN cycles with threshold=1, saturating at 255
max_count  output  N  largest counterN sampled during RUN

Behaviour:
- All outputs are registered. Reset has priority over every other input and is applied at the next rising edge.
- Reset values: enable=load=dec=0, load_ref_value=0, step=0, busy=0, done=0, thr_hits=0, max_count=0, state=IDLE, hold timer=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Control outputs are 0 and busy=0.
  - start=1 at edge k causes the transition to RUN, effective at cycle k+1.
  - The same edge captures ref_value into load_ref_value, clears thr_hits and max_count, and sets step=0 and timer=0.
- RUN:
  - busy=1 and {enable,load,dec}=step.
  - Step order is 0,1,...,7: (000 idle, 001 dec only, 010 load, 011 load+dec, 100 count up, 101 count down, 110 enable+load, 111 enable+load+dec).
  - Each cycle, timer increments. When timer==HOLD_CYCLES-1, timer resets to 0 and step increments; if step==7, the FSM goes to DONE instead.
  - With HOLD_CYCLES=1, step advances every cycle.
  - Each RUN cycle with threshold=1 increments thr_hits unless it is already 255.
  - Each RUN cycle with counterN > max_count (unsigned) loads counterN into max_count.
  - The feedback sampled in a cycle is the counter's response to the controls of the previous cycle; no compensation is applied.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, controls 0, step holds 7. The FSM then returns to IDLE and step returns to 0.
- Total latency: with start sampled at edge k, RUN occupies cycles k+1..k+8*HOLD_CYCLES and done=1 in cycle k+8*HOLD_CYCLES+1.
- start is ignored in RUN and DONE. There is no queuing; a new start is accepted only in IDLE, at the earliest the cycle after done.
- Results persist: thr_hits, max_count and load_ref_value hold their values in IDLE until the next accepted start.
- Reset mid-sweep aborts the sweep: all outputs go to reset values and no done pulse is produced.
- Simultaneous reset and start: reset wins and start is lost.

Decomposition:
- Shared package counter_seq_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - STEP_LAST = 3'd7
  - THR_SAT = 8'd255
  - bit-position constants STEP_EN=2, STEP_LD=1, STEP_DEC=0
- One natural sub-module: hold_timer, a parameterised HOLD_CYCLES down/up counter with clear input and a terminal-count output. All other logic stays in the top-level FSM.

Test Plan:
- Reset: assert reset for 2 cycles with start=1 -> all outputs 0; no RUN entry while reset is high.
- Full sweep, HOLD_CYCLES=4, ref_value=4'hF, start pulsed at edge 0:
  - busy=1 in cycles 1..32; step=0 in cycles 1-4, 1 in 5-8, ... 7 in 29-32
  - {enable,load,dec} equals step in every RUN cycle; load_ref_value=4'hF throughout
  - done=1 only in cycle 33
- Threshold counting, HOLD_CYCLES=4:
  - threshold=1 for exactly 10 RUN cycles -> thr_hits=10 after done
  - HOLD_CYCLES=40 with threshold held at 1 -> thr_hits saturates at 255, not 64
- max_count: counterN driven 3, 9, 5, 0 on successive RUN cycles, 0 otherwise -> max_count=9 after done, held through IDLE.
- Ignored start, HOLD_CYCLES=4: extra start pulses at cycles 10 and 33 -> step sequence unchanged, single done at cycle 33, FSM in IDLE at cycle 34; a start at cycle 34 begins a new sweep.
- Abort: reset pulsed at cycle 15 of a HOLD_CYCLES=4 sweep -> cycle 16 shows all outputs 0 and thr_hits=0; no done for the aborted sweep.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
// The step index is packed as {enable, load, dec}, so a step value maps directly onto the counter's control pins.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  localparam logic [2:0] STEP_LAST = 3'd7;
  localparam logic [7:0] THR_SAT   = 8'd255;

  // Bit positions of each control within the step index
  localparam int STEP_EN  = 2;
  localparam int STEP_LD  = 1;
  localparam int STEP_DEC = 0;

endpackage

// File: rtl/counter_cmd_sequencer_hold_timer.sv
// Hold timer: counts enabled cycles from 0 up to HOLD_CYCLES-1 and then wraps to 0.
// tc is high while the count sits on its last value, which marks the final cycle of a step.
module hold_timer #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [15:0] TC_VALUE = 16'(HOLD_CYCLES - 1);

  logic [15:0] count;

  // NOTE: registers are written with non-blocking (<=) assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 16'd1;
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Sweeps the counter's {enable, load, dec} controls through all 8 combinations, holding each for HOLD_CYCLES cycles.
// While sweeping it counts threshold hits and tracks the largest counterN value seen.
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] ref_value,
  input  logic [N-1:0] counterN,
  input  logic         threshold,
  output logic         enable,
  output logic         load,
  output logic         dec,
  output logic [N-1:0] load_ref_value,
  output logic [2:0]   step,
  output logic         busy,
  output logic         done,
  output logic [7:0]   thr_hits,
  output logic [N-1:0] max_count
);

  seq_state_t   state, state_nx;
  logic [2:0]   step_nx, ctrl_nx;
  logic [N-1:0] ref_nx, max_nx;
  logic [7:0]   thr_nx;
  logic         busy_nx, done_nx;
  logic         timer_clr, timer_en, timer_tc;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  // NOTE: every always_comb output gets a default first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_nx  = state;
    step_nx   = step;
    ref_nx    = load_ref_value;
    thr_nx    = thr_hits;
    max_nx    = max_count;
    ctrl_nx   = 3'b000;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          ref_nx    = ref_value;
          thr_nx    = '0;
          max_nx    = '0;
          step_nx   = '0;
          timer_clr = 1'b1;
          busy_nx   = 1'b1;
        end
      end

      RUN: begin
        timer_en = 1'b1;
        // Feedback is taken as-is; it reflects the controls of the previous cycle.
        if (threshold && thr_hits != THR_SAT) thr_nx = thr_hits + 8'd1;
        if (counterN > max_count)             max_nx = counterN;

        if (timer_tc && step == STEP_LAST) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          busy_nx = 1'b1;
          if (timer_tc) step_nx = step + 3'd1;
          ctrl_nx = step_nx;
        end
      end

      DONE: begin
        state_nx = IDLE;
        step_nx  = '0;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      step           <= '0;
      enable         <= 1'b0;
      load           <= 1'b0;
      dec            <= 1'b0;
      load_ref_value <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      thr_hits       <= '0;
      max_count      <= '0;
    end else begin
      state          <= state_nx;
      step           <= step_nx;
      enable         <= ctrl_nx[STEP_EN];
      load           <= ctrl_nx[STEP_LD];
      dec            <= ctrl_nx[STEP_DEC];
      load_ref_value <= ref_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      thr_hits       <= thr_nx;
      max_count      <= max_nx;
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer: one instance with HOLD_CYCLES=4 and one with HOLD_CYCLES=40 for saturation.
// Inputs change and outputs are sampled on the falling edge; "cycle c" is the period after rising edge c-1.
module tb_counter_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ref_value;
  logic [3:0] counter_n;
  logic       start_a, start_b;
  logic       thr_a, thr_b;

  logic       en_a, ld_a, dec_a, busy_a, done_a;
  logic [3:0] lref_a, max_a;
  logic [2:0] step_a;
  logic [7:0] hits_a;

  logic       en_b, ld_b, dec_b, busy_b, done_b;
  logic [3:0] lref_b, max_b;
  logic [2:0] step_b;
  logic [7:0] hits_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  counter_cmd_sequencer #(.N(4), .HOLD_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .ref_value(ref_value),
    .counterN(counter_n), .threshold(thr_a),
    .enable(en_a), .load(ld_a), .dec(dec_a), .load_ref_value(lref_a),
    .step(step_a), .busy(busy_a), .done(done_a), .thr_hits(hits_a), .max_count(max_a)
  );

  counter_cmd_sequencer #(.N(4), .HOLD_CYCLES(40)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .ref_value(ref_value),
    .counterN(counter_n), .threshold(thr_b),
    .enable(en_b), .load(ld_b), .dec(dec_b), .load_ref_value(lref_b),
    .step(step_b), .busy(busy_b), .done(done_b), .thr_hits(hits_b), .max_count(max_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " ctrl"}, {29'd0, en_a, ld_a, dec_a}, 32'd0);
    check({tag, " step"}, {29'd0, step_a}, 32'd0);
    check({tag, " busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, " done"}, {31'd0, done_a}, 32'd0);
    check({tag, " lref"}, {28'd0, lref_a}, 32'd0);
    check({tag, " hits"}, {24'd0, hits_a}, 32'd0);
    check({tag, " max"},  {28'd0, max_a}, 32'd0);
  endtask

  initial begin
    int exp_step, exp_thr, exp_max, first_done, done_cnt;

    reset = 1'b1; start_a = 1'b1; start_b = 1'b1;
    ref_value = 4'hF; counter_n = 4'd0; thr_a = 1'b0; thr_b = 1'b0;
    @(negedge clock);

    // Reset held for two edges with start high: nothing may leave IDLE.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check_a_zero("reset_a");
      check("reset_b busy", {31'd0, busy_b}, 32'd0);
      check("reset_b hits", {24'd0, hits_b}, 32'd0);
    end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    next_cycle();
    check("post_reset busy_a", {31'd0, busy_a}, 32'd0);
    check("post_reset busy_b", {31'd0, busy_b}, 32'd0);

    // Sweep A: start sampled at edge 0.
    start_a = 1'b1; ref_value = 4'hF;
    next_cycle();
    start_a = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      exp_step = (c <= 32) ? (c - 1) / 4 : (c == 33 ? 7 : 0);
      exp_thr  = (c <= 3) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
      exp_max  = (c <= 1) ? 0 : (c == 2 ? 3 : 9);
      check($sformatf("sweep busy c%0d", c), {31'd0, busy_a}, (c <= 32) ? 32'd1 : 32'd0);
      check($sformatf("sweep done c%0d", c), {31'd0, done_a}, (c == 33) ? 32'd1 : 32'd0);
      check($sformatf("sweep step c%0d", c), {29'd0, step_a}, 32'(exp_step));
      check($sformatf("sweep ctrl c%0d", c), {29'd0, en_a, ld_a, dec_a},
            (c <= 32) ? 32'(exp_step) : 32'd0);
      check($sformatf("sweep lref c%0d", c), {28'd0, lref_a}, 32'hF);
      check($sformatf("sweep hits c%0d", c), {24'd0, hits_a}, 32'(exp_thr));
      check($sformatf("sweep max c%0d", c),  {28'd0, max_a}, 32'(exp_max));

      // Inputs for cycle c, sampled at the edge that ends it.
      thr_a     = (c >= 3 && c <= 12);
      counter_n = (c == 1) ? 4'd3 : (c == 2) ? 4'd9 : (c == 3) ? 4'd5 : 4'd0;
      start_a   = (c == 10 || c == 33 || c == 34);
      ref_value = (c == 10 || c == 34) ? 4'h5 : 4'hF;
      next_cycle();
    end

    // Second sweep (accepted at edge 34) then reset at its cycle 15.
    start_a = 1'b0; ref_value = 4'hF; counter_n = 4'd0;
    for (int l = 1; l <= 16; l++) begin
      if (l <= 15) begin
        check($sformatf("sweep2 busy l%0d", l), {31'd0, busy_a}, 32'd1);
        check($sformatf("sweep2 step l%0d", l), {29'd0, step_a}, 32'((l - 1) / 4));
        check($sformatf("sweep2 lref l%0d", l), {28'd0, lref_a}, 32'h5);
        check($sformatf("sweep2 hits l%0d", l), {24'd0, hits_a}, 32'(l - 1));
        check($sformatf("sweep2 max l%0d", l),  {28'd0, max_a}, 32'd0);
      end else begin
        check_a_zero("abort");
      end
      thr_a = (l <= 14);
      reset = (l == 15);
      next_cycle();
    end

    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a || busy_a) done_cnt++;
      next_cycle();
    end
    check("abort no_done_no_busy", 32'(done_cnt), 32'd0);

    // Sweep B: threshold held high for 320 RUN cycles, hit counter must saturate.
    thr_b = 1'b1; start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    first_done = 0; done_cnt = 0;
    for (int c = 1; c <= 330; c++) begin
      if (done_b) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (c == 255) check("sat hits c255", {24'd0, hits_b}, 32'd254);
      if (c == 256) check("sat hits c256", {24'd0, hits_b}, 32'd255);
      if (c == 257) check("sat hits c257", {24'd0, hits_b}, 32'd255);
      if (c == 320) check("sat step c320", {29'd0, step_b}, 32'd7);
      next_cycle();
    end
    check("sat done cycle", 32'(first_done), 32'd321);
    check("sat done count", 32'(done_cnt), 32'd1);
    check("sat hits final", {24'd0, hits_b}, 32'd255);
    check("sat busy final", {31'd0, busy_b}, 32'd0);
    check("sat lref final", {28'd0, lref_b}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
